// File: rtl/gray_ctrl.sv
// ============================================================================
// Module      : gray_ctrl
// Description : Run controller for a 3-bit Gray counter. It issues exactly Len
//               enable steps per run, counts wraps and checks the Gray sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_ctrl #(
  parameter int LEN_W  = 8,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_pause,
  input  logic              i_abort,
  input  logic [2:0]        i_gray,
  input  logic              i_ovf,
  output logic              o_cnt_en,
  output logic              o_cnt_clr,
  output logic              o_busy,
  output logic              o_done,
  output logic [WRAP_W-1:0] o_wraps,
  output logic              o_err
);

  localparam logic [WRAP_W-1:0] c_wrap_max = {WRAP_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_rem;
  logic [WRAP_W-1:0]  r_wraps;
  logic               r_err;
  logic [2:0]         r_prev_gray;
  logic               r_prev_ovf;
  logic               r_prev_en;
  logic               r_first;

  logic               w_cnt_en;
  logic [2:0]         w_diff;
  logic               w_one_bit;
  logic               w_viol;

  // Enable follows Pause within the same RUN cycle so the step count stays
  // exact; Abort also gates it so the aborting cycle never steps the counter.
  assign w_cnt_en  = (r_state == S_RUN) && !i_pause && !i_abort;

  assign w_diff    = i_gray ^ r_prev_gray;
  assign w_one_bit = (w_diff != 3'd0) && ((w_diff & (w_diff - 3'd1)) == 3'd0);
  assign w_viol    = r_prev_en ? !w_one_bit : (w_diff != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_wraps     <= '0;
      r_err       <= 1'b0;
      r_prev_gray <= 3'd0;
      r_prev_ovf  <= 1'b0;
      r_prev_en   <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      r_prev_gray <= i_gray;
      r_prev_ovf  <= i_ovf;
      r_prev_en   <= w_cnt_en;
      r_first     <= (r_state == S_CLR);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wraps <= '0;
            r_err   <= 1'b0;
            r_rem   <= i_len;
            r_state <= (i_len == '0) ? S_DONE : S_CLR;
          end
        end
        S_CLR: begin
          r_state <= i_abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (i_ovf && !r_prev_ovf && (r_wraps != c_wrap_max)) begin
            r_wraps <= r_wraps + WRAP_W'(1);
          end
          // The first RUN cycle still compares against the pre-clear sample.
          if (!r_first && w_viol) begin
            r_err <= 1'b1;
          end
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (w_cnt_en) begin
            if (r_rem == LEN_W'(1)) begin
              r_rem   <= '0;
              r_state <= S_DONE;
            end else begin
              r_rem <= r_rem - LEN_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cnt_en  = w_cnt_en;
  assign o_cnt_clr = (r_state == S_CLR);
  assign o_busy    = (r_state == S_CLR) || (r_state == S_RUN);
  assign o_done    = (r_state == S_DONE);
  assign o_wraps   = r_wraps;
  assign o_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gray_ctrl.sv
// ============================================================================
// Module      : tb_gray_ctrl
// Description : Randomized scoreboard bench for gray_ctrl with an attached
//               3-bit Gray counter model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_ctrl;

  localparam int LEN_W  = 8;
  localparam int WRAP_W = 4;
  localparam int WMAX   = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [LEN_W-1:0]  i_len = '0;
  logic              i_pause = 1'b0;
  logic              i_abort = 1'b0;
  logic [2:0]        i_gray;
  logic              i_ovf;
  logic              o_cnt_en, o_cnt_clr, o_busy, o_done, o_err;
  logic [WRAP_W-1:0] o_wraps;

  gray_ctrl #(.LEN_W(LEN_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_pause(i_pause), .i_abort(i_abort), .i_gray(i_gray), .i_ovf(i_ovf),
    .o_cnt_en(o_cnt_en), .o_cnt_clr(o_cnt_clr), .o_busy(o_busy),
    .o_done(o_done), .o_wraps(o_wraps), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Attached counter; fault_en makes the 001 step jump to 010.
  bit       fault_en = 1'b0;
  int       cbin;
  logic     covf;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cbin <= 0;
      covf <= 1'b0;
    end else begin
      covf <= o_cnt_en && !o_cnt_clr && (cbin == 7);
      if (o_cnt_clr) cbin <= 0;
      else if (o_cnt_en) cbin <= (fault_en && cbin == 1) ? 3 : (cbin + 1) % 8;
    end
  end
  assign i_gray = 3'(cbin ^ (cbin >> 1));
  assign i_ovf  = covf;

  typedef struct {
    int kind;      // 0 = done pulse, 1 = abort
    int en;
    int clr;
    int wraps;
    int err;
    int gray;
    bit chk_gray;
  } exp_t;
  exp_t q[$];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int gray_of(input int b);
    int m;
    m = b % 8;
    return m ^ (m >> 1);
  endfunction

  function automatic int sat(input int v);
    return (v > WMAX) ? WMAX : v;
  endfunction

  // Monitor: counts enable/clear cycles per run and checks at each run end.
  int  en_cnt = 0, clr_cnt = 0;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      en_cnt = 0; clr_cnt = 0; prev_busy = 1'b0;
    end else begin
      check("en_clr_exclusive", int'(o_cnt_en & o_cnt_clr), 0);
      if (o_cnt_clr) clr_cnt++;
      if (o_cnt_en)  en_cnt++;
      if (o_done || (prev_busy && !o_busy)) begin
        if (q.size() == 0) begin
          check("unexpected_run_end", 1, 0);
        end else begin
          e = q.pop_front();
          check("end_kind", o_done ? 0 : 1, e.kind);
          check("busy_at_end", int'(o_busy), 0);
          check("en_cycles", en_cnt, e.en);
          check("clr_cycles", clr_cnt, e.clr);
          check("wraps", int'(o_wraps), e.wraps);
          check("err", int'(o_err), e.err);
          if (e.chk_gray) check("gray_at_end", int'(i_gray), e.gray);
        end
        en_cnt = 0; clr_cnt = 0;
      end
      prev_busy = o_busy;
    end
  end

  // pmode: 0 none, 1 random 25%, 2 pause RUN cycles 2..4.
  task automatic run(input int len, input int pmode, input int abort_at,
                     input bit start_mid, input int rst_at);
    exp_t e;
    int   steps;
    bit   p;
    i_start = 1'b1;
    i_len   = len[LEN_W-1:0];
    @(posedge clk); #1;
    i_start = 1'b0;
    if (len == 0) begin
      e = '{0, 0, 0, 0, 0, 0, 1'b0};
      q.push_back(e);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    steps = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      case (pmode)
        1: p = ($urandom_range(0, 3) == 0);
        2: p = (cyc >= 2 && cyc <= 4);
        default: p = 1'b0;
      endcase
      i_start = start_mid && (cyc == 1);
      i_len   = (start_mid && cyc == 1) ? LEN_W'(2) : len[LEN_W-1:0];
      i_pause = p;
      if (cyc == rst_at) begin
        i_pause = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_cnt_en",  int'(o_cnt_en), 0);
        check("rst_cnt_clr", int'(o_cnt_clr), 0);
        check("rst_busy",    int'(o_busy), 0);
        check("rst_done",    int'(o_done), 0);
        check("rst_wraps",   int'(o_wraps), 0);
        check("rst_err",     int'(o_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (cyc == abort_at) begin
        i_abort = 1'b1;
        e.kind = 1; e.en = steps; e.clr = 1; e.wraps = sat(steps / 8);
        e.err = (fault_en && steps >= 2) ? 1 : 0;
        e.gray = gray_of((fault_en && steps >= 2) ? steps + 1 : steps);
        e.chk_gray = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        i_abort = 1'b0;
        break;
      end
      if (!p) begin
        steps++;
        if (steps == len) begin
          e.kind = 0; e.en = len; e.clr = 1; e.wraps = sat((len - 1) / 8);
          e.err = (fault_en && len > 2) ? 1 : 0;
          e.gray = gray_of((fault_en && len >= 2) ? len + 1 : len);
          e.chk_gray = 1'b1;
          q.push_back(e);
          @(posedge clk); #1;
          i_pause = 1'b0;
          i_start = 1'b0;
          @(posedge clk); #1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_pause = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, queue %0d expected 0", q.size());
    $fatal(1);
  end

  initial begin
    int l, ab;
    #3;
    check("reset_cnt_en",  int'(o_cnt_en), 0);
    check("reset_cnt_clr", int'(o_cnt_clr), 0);
    check("reset_busy",    int'(o_busy), 0);
    check("reset_done",    int'(o_done), 0);
    check("reset_wraps",   int'(o_wraps), 0);
    check("reset_err",     int'(o_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(5, 0, -1, 1'b0, -1);
    run(10, 0, -1, 1'b0, -1);
    run(6, 2, -1, 1'b0, -1);
    run(8, 0, 3, 1'b1, -1);
    fault_en = 1'b1;
    run(5, 0, -1, 1'b0, -1);
    fault_en = 1'b0;
    run(0, 0, -1, 1'b0, -1);
    run(20, 0, -1, 1'b0, 6);
    run(3, 0, -1, 1'b0, -1);
    run(255, 1, -1, 1'b0, -1);
    run(1, 0, -1, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      l  = $urandom_range(0, 40);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l + 4) : -1;
      run(l, 1, ab, $urandom_range(0, 1) == 1, -1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
